inst_cache: RTL

Direct-mapped, blocking instruction cache between the IF0/IF1 pipeline registers and the instruction-memory bus. IF0 presents a fetch address each cycle. The lookup completes in IF1, and `ready` tells IF1 whether `inst` is usable. On a miss the cache refills one line by burst read, holds `ready` low so IF1 stalls the PC and flushes IF1_ID, then returns the missed word.

---
 rtl/inst_cache_pkg.sv | 15 +
 rtl/cache_sram.sv | 26 ++
 rtl/inst_cache.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: CPU word width, default cache
// geometry and FSM state encodings.
package inst_cache_pkg;

    localparam int CPU_WORD          = 32;
    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

endpackage

// File: rtl/cache_sram.sv
// Single write port RAM with a registered (synchronous) read port.
// The contents are deliberately not reset.
module cache_sram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped blocking instruction cache: the lookup runs in IF1 and a miss
// refills one whole line by burst before returning the missed word.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int WORD       = CPU_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [WORD-1:0] req_addr,
    input  logic            cancel,
    output logic            ready,
    output logic [WORD-1:0] inst,
    output logic            mem_req,
    output logic [WORD-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [WORD-1:0] mem_rdata,
    input  logic            mem_rlast
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = WORD - OFF_W - IDX_W - 2;
    localparam int LINE_W = LINE_WORDS * WORD;

    logic [2:0]                       state_q, state_d;
    logic                             req_v_q, req_v_d;
    logic [WORD-1:0]                  req_addr_q, req_addr_d;
    logic [WORD-1:0]                  miss_addr_q, miss_addr_d;
    logic                             kill_q, kill_d;
    logic [OFF_W-1:0]                 cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][WORD-1:0]  buf_q, buf_d;
    logic [SETS-1:0]                  valid_q, valid_d;

    logic [LINE_W-1:0]                line_rd;
    logic [LINE_WORDS-1:0][WORD-1:0]  line_words;
    logic [TAG_W-1:0]                 tag_rd;
    logic                             lookup, hit, resp_ok, ram_we;
    logic                             unused_bits;

    wire [OFF_W-1:0] req_off  = req_addr_q[2 +: OFF_W];
    wire [IDX_W-1:0] req_idx  = req_addr_q[2+OFF_W +: IDX_W];
    wire [TAG_W-1:0] req_tag  = req_addr_q[WORD-1 -: TAG_W];
    wire [OFF_W-1:0] miss_off = miss_addr_q[2 +: OFF_W];
    wire [IDX_W-1:0] miss_idx = miss_addr_q[2+OFF_W +: IDX_W];
    wire [TAG_W-1:0] miss_tag = miss_addr_q[WORD-1 -: TAG_W];

    assign unused_bits = &{1'b0, req_addr_q[1:0], miss_addr_q[1:0]};

    // RAMs are read with the IF0 address so the line is available alongside req_addr_q.
    cache_sram #(.DEPTH(SETS), .WIDTH(LINE_W), .AW(IDX_W)) u_data (
        .clk(clk), .we(ram_we), .waddr(miss_idx), .wdata(buf_q),
        .raddr(req_addr[2+OFF_W +: IDX_W]), .rdata(line_rd)
    );

    cache_sram #(.DEPTH(SETS), .WIDTH(TAG_W), .AW(IDX_W)) u_tag (
        .clk(clk), .we(ram_we), .waddr(miss_idx), .wdata(miss_tag),
        .raddr(req_addr[2+OFF_W +: IDX_W]), .rdata(tag_rd)
    );

    assign line_words = line_rd;
    assign ram_we     = (state_q == S_WRITE);
    assign lookup     = (state_q == S_IDLE) && req_v_q && !cancel;
    assign hit        = lookup && valid_q[req_idx] && (tag_rd == req_tag);
    assign resp_ok    = (state_q == S_RESP) && !kill_q && !cancel;
    assign ready      = hit || resp_ok;
    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = {miss_addr_q[WORD-1:OFF_W+2], {(OFF_W+2){1'b0}}};

    always_comb begin
        inst = '0;
        if (hit)          inst = line_words[req_off];
        else if (resp_ok) inst = buf_q[miss_off];
    end

    always_comb begin
        state_d     = state_q;
        req_v_d     = req_v_q;
        req_addr_d  = req_addr_q;
        miss_addr_d = miss_addr_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        valid_d     = valid_q;
        case (state_q)
            S_IDLE: if (lookup && !hit) begin
                state_d     = S_REQ;
                miss_addr_d = req_addr_q;
            end
            S_REQ: if (mem_gnt) begin
                state_d = S_FILL;
                cnt_d   = '0;
            end
            S_FILL: if (mem_rvalid) begin
                buf_d[cnt_q] = mem_rdata;
                cnt_d        = cnt_q + 1'b1;
                if (mem_rlast) state_d = S_WRITE;
            end
            S_WRITE: begin
                valid_d[miss_idx] = 1'b1;
                state_d           = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
        // A redirect mid-refill still installs the line but drops the response.
        if (cancel && (state_q == S_REQ || state_q == S_FILL || state_q == S_WRITE))
            kill_d = 1'b1;
        if (state_q == S_RESP)
            kill_d = 1'b0;
        if (state_d == S_IDLE) begin
            req_v_d    = req_valid;
            req_addr_d = req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_v_q     <= 1'b0;
            req_addr_q  <= '0;
            miss_addr_q <= '0;
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_v_q     <= req_v_d;
            req_addr_q  <= req_addr_d;
            miss_addr_q <= miss_addr_d;
            kill_q      <= kill_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            valid_q     <= valid_d;
        end
    end

endmodule
